instruction_cache: RTL
======================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache on the fetch side of the IF/ID register.
//  Takes the fetch PC and returns INSTRUCTION together with BUSY_WAIT.
//  BUSY_WAIT stalls the PC register and the IF/ID pipeline register.
//  On a miss, fetches the whole block from instruction memory over a read/busywait handshake.
// PARAMETERS
//  BLOCKS       8   number of cache blocks, power of 2; index = PC[4+log2(BLOCKS)-1:4]
//  BLOCK_WORDS  4   32-bit words per block, fixed at 4 (16-byte block); offset = PC[3:2]
// PORTS
//  CLK            in   1    clock; all state updates on posedge. Single clock domain.
//  RESET          in   1    synchronous, active-high reset
//  PC             in   32   fetch byte address from the PC unit; PC[1:0] ignored
//  INSTRUCTION    out  32   fetched instruction, to the IF/ID register
//  BUSY_WAIT      out  1    1 = instruction not valid; stall PC and IF/ID
//  MEM_READ       out  1    read request to instruction memory
//  MEM_ADDRESS    out  28   block address = {tag,index} = PC[31:4] of the missing block
//  MEM_READDATA   in   128  block from memory; word k = bits [32k+31:32k]
//  MEM_BUSYWAIT   in   1    memory busy; data valid in a cycle with MEM_READ=1 and MEM_BUSYWAIT=0
// BEHAVIOUR
//  Reset (posedge CLK with RESET=1):
//   - all valid bits cleared; state forced to IDLE.
//   - MEM_READ=0, MEM_ADDRESS=0, BUSY_WAIT=0, INSTRUCTION=0.
//   - Tag/data arrays are not cleared.
//  Sentinel: PC==32'hFFFF_FFFC is the post-reset PC (PC+4 register resets to -4).
//   - In IDLE this gives INSTRUCTION=0, BUSY_WAIT=0 and starts no miss.
//  hit = valid[idx] && (tag[idx]==PC tag bits). Comb. outputs from PC and state.
//  IDLE:
//   - hit: INSTRUCTION = data[idx][offset] in the same cycle (0-cycle hit latency), BUSY_WAIT=0.
//   - miss: BUSY_WAIT=1 in the same cycle.
//     Latch miss_addr=PC[31:4] and miss_idx; next state MEM_RD.
//  MEM_RD:
//   - MEM_READ=1, MEM_ADDRESS=miss_addr, BUSY_WAIT=1.
//   - Stay while MEM_BUSYWAIT=1.
//   - When MEM_BUSYWAIT=0: capture MEM_READDATA into the fill register; next state UPDATE.
//  UPDATE:
//   - MEM_READ=0, BUSY_WAIT=1.
//   - Write fill data, tag and valid=1 into block miss_idx; next state IDLE.
//   - The next IDLE cycle hits for the same PC; BUSY_WAIT drops there.
//  Miss penalty: 1 (IDLE) + N (MEM_RD cycles incl. the data cycle) + 1 (UPDATE) cycles of BUSY_WAIT=1.
//  The fill always uses the latched miss_addr. PC changes during MEM_RD/UPDATE do not alter the request.
//   - A different PC seen back in IDLE is looked up afresh.
//  A miss replaces the resident block unconditionally; there is no write-back (read-only).
//  Reset mid-fill (MEM_RD or UPDATE):
//   - Abort; MEM_READ=0 from the next cycle.
//   - The partial block is discarded, no array write occurs, and all valid bits are 0.
//  RESET takes priority over every other event in the same cycle.
//  INSTRUCTION when BUSY_WAIT=1: don't-care, but stable within a cycle (no X on hit path).
// TESTING
//  Memory model: data = f(address), MEM_BUSYWAIT high for 4 cycles after MEM_READ rises.
//  Test cases:
//  1. RESET 1 cycle, PC=32'hFFFF_FFFC -> BUSY_WAIT=0, INSTRUCTION=0, MEM_READ=0.
//  2. Cold miss: PC=0x00000000 -> BUSY_WAIT=1 immediately.
//     MEM_READ=1 with MEM_ADDRESS=0. BUSY_WAIT stays 1 for 1+5+1=7 cycles.
//     Then INSTRUCTION = word0 of block 0 and BUSY_WAIT=0.
//  3. Same-block hits: PC=0x4, 0x8, 0xC on consecutive cycles -> words 1..3 returned,
//     BUSY_WAIT=0, MEM_READ never asserted.
//  4. Conflict: PC=0x80 (index 0, new tag) -> miss with MEM_ADDRESS=0x8.
//     After the fill, PC=0x0 misses again (block evicted).
//  5. PC changed to 0x40 during MEM_RD -> MEM_ADDRESS stays at the original block.
//     Back in IDLE, PC=0x40 triggers its own miss.
//  6. RESET asserted in the 2nd MEM_RD cycle -> MEM_READ=0 next cycle.
//     A following PC=0x0 misses (valid cleared); no stale data is returned.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache between the PC unit and the IF/ID register.
// Hits return in the same cycle; misses stall with BUSY_WAIT while a 16-byte block is filled.
module instruction_cache #(
   parameter int BLOCKS      = 8,
   parameter int BLOCK_WORDS = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [31:0]               PC,
   output logic [31:0]               INSTRUCTION,
   output logic                      BUSY_WAIT,
   output logic                      MEM_READ,
   output logic [27:0]               MEM_ADDRESS,
   input  logic [32*BLOCK_WORDS-1:0] MEM_READDATA,
   input  logic                      MEM_BUSYWAIT
);

   localparam int IDX_W  = $clog2(BLOCKS);
   localparam int TAG_W  = 28 - IDX_W;
   localparam int LINE_W = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {IDLE, MEM_RD, UPDATE} state_t;

   state_t              state, next_state;
   logic [BLOCKS-1:0]   valid;
   logic [TAG_W-1:0]    tag_mem  [BLOCKS];
   logic [LINE_W-1:0]   data_mem [BLOCKS];
   logic [27:0]         miss_addr;
   logic [LINE_W-1:0]   fill_line;

   logic [IDX_W-1:0]    pc_idx;
   logic [IDX_W-1:0]    miss_idx;
   logic [TAG_W-1:0]    pc_tag;
   logic [1:0]          pc_off;
   logic [31:0]         hit_word;
   logic                sentinel;
   logic                hit;
   logic                start_miss;
   logic                pc_unused;

   assign pc_idx    = PC[4 +: IDX_W];
   assign pc_tag    = PC[31 -: TAG_W];
   assign pc_off    = PC[3:2];
   assign pc_unused = ^PC[1:0];
   assign miss_idx  = miss_addr[IDX_W-1:0];
   assign sentinel  = (PC == 32'hFFFF_FFFC);
   assign hit       = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
   assign hit_word  = data_mem[pc_idx][{pc_off, 5'b00000} +: 32];

   // Lookup stage: outputs are combinational from PC and state
   always_comb begin
      next_state  = state;
      INSTRUCTION = 32'h0;
      BUSY_WAIT   = 1'b0;
      MEM_READ    = 1'b0;
      MEM_ADDRESS = 28'h0;
      start_miss  = 1'b0;
      case (state)
         IDLE: begin
            if (!sentinel) begin
               if (hit) begin
                  INSTRUCTION = hit_word;
               end else begin
                  BUSY_WAIT  = 1'b1;
                  start_miss = 1'b1;
                  next_state = MEM_RD;
               end
            end
         end
         MEM_RD: begin
            MEM_READ    = 1'b1;
            MEM_ADDRESS = miss_addr;
            BUSY_WAIT   = 1'b1;
            if (!MEM_BUSYWAIT) next_state = UPDATE;
         end
         UPDATE: begin
            BUSY_WAIT  = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Control state: reset aborts any fill in flight and invalidates every block
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         valid <= '0;
      end else begin
         state <= next_state;
         if (state == UPDATE) valid[miss_idx] <= 1'b1;
      end
   end

   // Fill stage: miss address, fill register and arrays are not reset
   always_ff @(posedge CLK) begin
      if (start_miss) miss_addr <= PC[31:4];
      if (state == MEM_RD && !MEM_BUSYWAIT) fill_line <= MEM_READDATA;
      if (state == UPDATE && !RESET) begin
         data_mem[miss_idx] <= fill_line;
         tag_mem[miss_idx]  <= miss_addr[27 -: TAG_W];
      end
   end

endmodule
